// File: rtl/grid_pkg.sv
// grid_pkg: shared grid geometry, cell codes, payload field offsets and coordinate helpers
package grid_pkg;
   localparam int GRID_X = 32;
   localparam int GRID_Y = 24;
   localparam int ADDR_W = 10;
   localparam int X_W = 5;
   localparam int CELLS = GRID_X * GRID_Y;
   localparam int DISP_MAX_CONSEC = 3;
   localparam logic [3:0] WALL_CODE = 4'b0010;
   localparam int WR_CODE_LSB = 0;
   localparam int WR_Y_LSB = 4;
   localparam int WR_X_LSB = 20;
   localparam int RD_Y_LSB = 0;
   localparam int RD_X_LSB = 16;
   typedef enum logic [3:0] {NULL = 4'd0, SNAKE = 4'd1, ROCK = 4'd2, SNACK = 4'd4} cell_t;
   typedef enum logic {SERVE, CLEAR} state_t;
   // full 16-bit compare so negative wraps such as 16'hFFFF land outside the grid
   function automatic logic in_grid(logic [15:0] x, logic [15:0] y);
      return 32'(x) < GRID_X && 32'(y) < GRID_Y;
   endfunction
   function automatic logic [ADDR_W-1:0] coord_to_addr(logic [15:0] x, logic [15:0] y);
      return {y[ADDR_W-X_W-1:0], x[X_W-1:0]};
   endfunction
   function automatic logic col_used(logic [ADDR_W-1:0] a);
      return 32'(a[X_W-1:0]) < GRID_X;
   endfunction
   localparam logic [ADDR_W-1:0] LAST_ADDR = coord_to_addr(16'(GRID_X - 1), 16'(GRID_Y - 1));
endpackage

// File: rtl/grid_rr_arbiter.sv
// grid_rr_arbiter: display-first RAM slot grant with starvation limit and write/read round-robin
module grid_rr_arbiter #(
   parameter int MAX_CONSEC = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic disp_req,
   input  logic wr_req,
   input  logic rd_req,
   output logic disp_gnt,
   output logic wr_gnt,
   output logic rd_gnt
);
   localparam int CW = $clog2(MAX_CONSEC + 1);
   logic [CW-1:0] consec;
   logic rr_rd, ctrl_req, ctrl_win;
   always_comb begin
      ctrl_req = wr_req || rd_req;
      ctrl_win = en && ctrl_req && (!disp_req || 32'(consec) >= MAX_CONSEC);
      wr_gnt = ctrl_win && wr_req && (!rd_req || !rr_rd);
      rd_gnt = ctrl_win && !wr_gnt;
      disp_gnt = en && disp_req && !ctrl_win;
   end
   // consec counts display grants taken while a controller request was left waiting
   always_ff @(posedge clk)
      if (rst) begin
         consec <= '0;
         rr_rd <= 1'b0;
      end else if (ctrl_win) begin
         consec <= '0;
         rr_rd <= !rr_rd;
      end else if (disp_gnt && ctrl_req)
         consec <= consec + 1'b1;
      else if (!ctrl_req)
         consec <= '0;
endmodule

// File: rtl/grid_access_arbiter.sv
// grid_access_arbiter: shares the single-port grid cell RAM between display reads,
// controller writes/reads and a full-grid clear sweep
module grid_access_arbiter
   import grid_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_start,
   output logic              clear_busy,
   input  logic              wr_valid,
   input  logic [35:0]       wr_data,
   output logic              wr_ready,
   input  logic              rd_valid,
   input  logic [31:0]       rd_coord,
   output logic              rd_ready,
   output logic [3:0]        rd_data,
   output logic              rd_data_valid,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic [3:0]        disp_data,
   output logic              disp_data_valid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [3:0]        ram_wdata,
   input  logic [3:0]        ram_rdata
);
   state_t state, state_nxt;
   logic [ADDR_W-1:0] sweep_cnt;
   logic [15:0] wr_x, wr_y, rd_x, rd_y;
   logic wr_in, rd_in, disp_in, serve, sweep_wr, wr_gnt, rd_gnt, disp_win;
   logic rd_tag, rd_wall, disp_tag, disp_void;

   assign wr_x = wr_data[WR_X_LSB +: 16];
   assign wr_y = wr_data[WR_Y_LSB +: 16];
   assign rd_x = rd_coord[RD_X_LSB +: 16];
   assign rd_y = rd_coord[RD_Y_LSB +: 16];
   assign wr_in = in_grid(wr_x, wr_y);
   assign rd_in = in_grid(rd_x, rd_y);
   assign disp_in = 32'(disp_addr) < CELLS;
   assign serve = state == SERVE && !clear_start;

   // only in-grid controller accesses compete for the RAM slot
   grid_rr_arbiter #(.MAX_CONSEC(DISP_MAX_CONSEC)) u_arb (
      .clk,
      .rst,
      .en(serve),
      .disp_req,
      .wr_req(wr_valid && wr_in),
      .rd_req(rd_valid && rd_in),
      .disp_gnt(disp_win),
      .wr_gnt,
      .rd_gnt
   );

   always_ff @(posedge clk)
      if (rst) begin
         state <= SERVE;
         sweep_cnt <= '0;
      end else begin
         state <= state_nxt;
         sweep_cnt <= state == CLEAR ? sweep_cnt + 1'b1 : '0;
      end

   always_comb
      state_nxt = state == SERVE ? (clear_start ? CLEAR : SERVE) : (sweep_cnt == LAST_ADDR ? SERVE : CLEAR);

   always_comb begin
      clear_busy = state == CLEAR || clear_start;
      sweep_wr = state == CLEAR && col_used(sweep_cnt);
      wr_ready = wr_gnt || (serve && wr_valid && !wr_in);
      rd_ready = rd_gnt || (serve && rd_valid && !rd_in);
      disp_gnt = disp_win;
      ram_en = sweep_wr || wr_gnt || rd_gnt || (disp_win && disp_in);
      ram_we = sweep_wr || wr_gnt;
      ram_addr = state == CLEAR ? sweep_cnt :
                 rd_gnt ? coord_to_addr(rd_x, rd_y) :
                 wr_gnt ? coord_to_addr(wr_x, wr_y) :
                 disp_win && disp_in ? disp_addr : '0;
      ram_wdata = wr_gnt ? wr_data[WR_CODE_LSB +: 4] : '0;
   end

   // one tag per reader; both can be live when an off-grid read rides alongside a display grant
   always_ff @(posedge clk)
      if (rst) begin
         rd_tag <= 1'b0;
         rd_wall <= 1'b0;
         disp_tag <= 1'b0;
         disp_void <= 1'b0;
      end else begin
         rd_tag <= rd_valid && rd_ready;
         rd_wall <= !rd_in;
         disp_tag <= disp_req && disp_gnt;
         disp_void <= !disp_in;
      end

   assign rd_data_valid = rd_tag;
   assign rd_data = rd_tag ? (rd_wall ? WALL_CODE : ram_rdata) : '0;
   assign disp_data_valid = disp_tag;
   assign disp_data = disp_tag && !disp_void ? ram_rdata : '0;
endmodule

// File: tb/tb_grid_access_arbiter.sv
// tb_grid_access_arbiter: directed stimulus with a cell-level grid model checked every cycle
module tb_grid_access_arbiter;
   localparam int GX = 32;
   localparam int GY = 24;
   localparam int NCELL = GX * GY;
   logic clk = 0, rst = 1, clear_start = 0, clear_busy;
   logic wr_valid = 0, wr_ready;
   logic [35:0] wr_data = '0;
   logic rd_valid = 0, rd_ready, rd_data_valid;
   logic [31:0] rd_coord = '0;
   logic [3:0] rd_data;
   logic disp_req = 0, disp_gnt, disp_data_valid;
   logic [9:0] disp_addr = '0;
   logic [3:0] disp_data;
   logic ram_en, ram_we;
   logic [9:0] ram_addr;
   logic [3:0] ram_wdata, ram_rdata;
   int checks = 0, errors = 0;
   logic [3:0] mem [1024];
   bit written [1024];
   logic [3:0] golden [NCELL];
   bit init_done = 0;
   logic exp_rd_v = 0, exp_dp_v = 0;
   logic [3:0] exp_rd_d = 0, exp_dp_d = 0;

   always #5 clk = ~clk;

   grid_access_arbiter dut (
      .clk(clk), .rst(rst), .clear_start(clear_start), .clear_busy(clear_busy),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_coord(rd_coord), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_data(disp_data), .disp_data_valid(disp_data_valid),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   function automatic logic [3:0] pat(int i);
      return 4'(i * 5 + 3);
   endfunction
   function automatic bit ingrid(logic [15:0] x, logic [15:0] y);
      return int'(x) < GX && int'(y) < GY;
   endfunction
   function automatic int lin(logic [15:0] x, logic [15:0] y);
      return int'(y) * GX + int'(x);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk)
      if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            written[ram_addr] <= 1'b1;
         end else
            ram_rdata <= written[ram_addr] ? mem[ram_addr] : pat(int'(ram_addr));
      end

   // grid model: cell contents tracked per accepted transfer, responses due one cycle later
   always @(negedge clk) begin
      logic [15:0] wx, wy, rx, ry;
      bit wi, ri, di, wacc, racc, dacc;
      int ops;
      logic ee, ew;
      logic [9:0] ea;
      logic [3:0] ed;
      if (!init_done) begin
         for (int i = 0; i < NCELL; i++) golden[i] = pat(i);
         init_done = 1;
      end
      if (rst) begin
         exp_rd_v = 0;
         exp_dp_v = 0;
      end else begin
         chk("rd_data_valid", rd_data_valid, exp_rd_v);
         if (exp_rd_v) chk("rd_data", rd_data, exp_rd_d);
         chk("disp_data_valid", disp_data_valid, exp_dp_v);
         if (exp_dp_v) chk("disp_data", disp_data, exp_dp_d);
         wx = wr_data[35:20];
         wy = wr_data[19:4];
         rx = rd_coord[31:16];
         ry = rd_coord[15:0];
         wi = ingrid(wx, wy);
         ri = ingrid(rx, ry);
         di = int'(disp_addr) < NCELL;
         wacc = wr_valid && wr_ready;
         racc = rd_valid && rd_ready;
         dacc = disp_req && disp_gnt;
         if (clear_busy) chk("quiet_while_busy", {wr_ready, rd_ready, disp_gnt}, 0);
         else begin
            if (wr_valid && !wi) chk("oog_write_accepted", wr_ready, 1);
            if (rd_valid && !ri) chk("oog_read_accepted", rd_ready, 1);
            ops = int'(wacc && wi) + int'(racc && ri) + int'(dacc && di);
            chk("one_ram_op", ops <= 1, 1);
            ee = 0; ew = 0; ea = 0; ed = 0;
            if (racc && ri) begin ee = 1; ea = 10'(lin(rx, ry)); end
            else if (wacc && wi) begin ee = 1; ew = 1; ea = 10'(lin(wx, wy)); ed = wr_data[3:0]; end
            else if (dacc && di) begin ee = 1; ea = disp_addr; end
            chk("ram_en", ram_en, ee);
            if (ee) begin
               chk("ram_we", ram_we, ew);
               chk("ram_addr", ram_addr, ea);
               if (ew) chk("ram_wdata", ram_wdata, ed);
            end
         end
         exp_rd_v = racc;
         exp_rd_d = ri ? golden[lin(rx, ry)] : 4'd2;
         exp_dp_v = dacc;
         exp_dp_d = di ? golden[disp_addr] : 4'd0;
         if (wacc && wi) golden[lin(wx, wy)] = wr_data[3:0];
         if (clear_start) for (int i = 0; i < NCELL; i++) golden[i] = 4'd0;
      end
   end

   task automatic sweep(output logic first, output int busy, output int writes, output int bad, output logic [4:0] resp0);
      busy = 0; writes = 0; bad = 0; first = 0; resp0 = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (c == 0) begin
            first = clear_busy;
            resp0 = {rd_data_valid, rd_data};
         end
         if (!clear_busy) break;
         busy++;
         if (ram_we) begin
            if (!ram_en || int'(ram_addr) != writes || ram_wdata != 0) bad++;
            writes++;
         end
         @(posedge clk); #1 clear_start = 0;
      end
      @(posedge clk); #1 clear_start = 0;
   endtask

   task automatic do_read(input logic [15:0] x, input logic [15:0] y, output logic [3:0] d, output logic en, output int lat);
      @(posedge clk); #1 rd_valid = 1; rd_coord = {x, y};
      lat = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rd_ready) begin lat = c; break; end
         @(posedge clk); #1;
      end
      en = ram_en;
      @(posedge clk); #1 rd_valid = 0;
      @(negedge clk);
      d = rd_data;
      chk("rd_strobe_next_cycle", rd_data_valid, 1);
   endtask

   task automatic do_write(input logic [15:0] x, input logic [15:0] y, input logic [3:0] code, output logic [9:0] a, output logic en, output int lat);
      @(posedge clk); #1 wr_valid = 1; wr_data = {x, y, code};
      lat = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (wr_ready) begin lat = c; break; end
         @(posedge clk); #1;
      end
      en = ram_en && ram_we;
      a = ram_addr;
      @(posedge clk); #1 wr_valid = 0;
   endtask

   task automatic do_disp(input logic [9:0] a, output logic g, output logic en, output logic [3:0] d);
      @(posedge clk); #1 disp_req = 1; disp_addr = a;
      @(negedge clk);
      g = disp_gnt;
      en = ram_en;
      @(posedge clk); #1 disp_req = 0;
      @(negedge clk);
      d = disp_data;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] d;
      logic en, g, fb, dg_at;
      logic [9:0] a;
      logic [4:0] resp;
      logic [15:0] seq;
      int lat, bc, wc, ob, slot, dg, nwe;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {clear_busy, wr_ready, rd_ready, rd_data_valid, rd_data, disp_gnt,
          disp_data_valid, disp_data, ram_en, ram_we, ram_addr, ram_wdata}, 0);
      @(posedge clk); #1 rst = 0;

      @(posedge clk); #1 clear_start = 1;
      sweep(fb, bc, wc, ob, resp);
      chk("clear_busy_same_cycle", fb, 1);
      chk("clear_busy_cycles", bc, 769);
      chk("clear_write_count", wc, 768);
      chk("clear_addr_order", ob, 0);
      do_read(16'd5, 16'd7, d, en, lat);
      chk("read_after_clear", d, 0);
      chk("read_accept_wait", lat, 0);

      do_write(16'd10, 16'd3, 4'd4, a, en, lat);
      chk("write_addr_10_3", a, 106);
      chk("write_ram_we", en, 1);
      do_read(16'd10, 16'd3, d, en, lat);
      chk("read_back_10_3", d, 4);
      do_disp(10'd106, g, en, d);
      chk("disp_gnt_106", g, 1);
      chk("disp_ram_en_106", en, 1);
      chk("disp_data_106", d, 4);
      do_disp(10'd800, g, en, d);
      chk("disp_gnt_800", g, 1);
      chk("disp_ram_en_800", en, 0);
      chk("disp_data_800", d, 0);

      do_read(16'hFFFF, 16'd5, d, en, lat);
      chk("oog_neg_ram_en", en, 0);
      chk("oog_neg_wall", d, 2);
      do_read(16'd32, 16'd0, d, en, lat);
      chk("oog_x32_ram_en", en, 0);
      chk("oog_x32_wall", d, 2);
      do_write(16'd32, 16'd0, 4'd1, a, en, lat);
      chk("oog_write_ram_we", en, 0);
      chk("oog_write_wait", lat, 0);
      do_read(16'd0, 16'd0, d, en, lat);
      chk("cell_0_0_untouched", d, 0);
      do_read(16'd0, 16'd1, d, en, lat);
      chk("cell_0_1_untouched", d, 0);

      @(posedge clk); #1 disp_req = 1; disp_addr = 10'd5; wr_valid = 1; wr_data = {16'd1, 16'd1, 4'd1};
      slot = 0; dg = 0; dg_at = 1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (wr_ready) begin slot = c; dg_at = disp_gnt; break; end
         dg += int'(disp_gnt);
         @(posedge clk); #1;
      end
      @(posedge clk); #1 wr_valid = 0;
      @(negedge clk);
      g = disp_gnt;
      @(posedge clk); #1 disp_req = 0;
      chk("starve_write_slot", slot, 4);
      chk("starve_disp_grants", dg, 3);
      chk("starve_disp_blocked", dg_at, 0);
      chk("starve_disp_resumes", g, 1);

      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      wr_valid = 1; wr_data = {16'd2, 16'd2, 4'd4}; rd_valid = 1; rd_coord = {16'd3, 16'd3};
      seq = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         seq = {seq[11:0], wr_ready ? 4'h1 : (rd_ready ? 4'h2 : 4'h0)};
         @(posedge clk); #1;
      end
      wr_valid = 0; rd_valid = 0;
      chk("rr_sequence", seq, 16'h1212);

      @(posedge clk); #1 rd_valid = 1; rd_coord = {16'd10, 16'd3};
      @(negedge clk);
      chk("inflight_accept", rd_ready, 1);
      @(posedge clk); #1 rd_valid = 0; clear_start = 1;
      sweep(fb, bc, wc, ob, resp);
      chk("inflight_response", resp, 5'h14);
      chk("inflight_clear_cycles", bc, 769);
      chk("inflight_clear_writes", wc, 768);
      chk("inflight_clear_order", ob, 0);

      @(posedge clk); #1 clear_start = 1;
      @(posedge clk); #1 clear_start = 0;
      repeat (99) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("abort_busy_low", clear_busy, 0);
      nwe = int'(ram_we);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         nwe += int'(ram_we);
      end
      chk("abort_no_writes", nwe, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
